seq_det_ctrl: RTL

Programmable, run-controlled serial sequence detector for the long-sequence detection path. It owns the detection shift register and adds a configuration handshake for pattern and mask. It sequences each run (arm, fill guard, match counting, overlap policy, timeout) and reports match events and a completion status to the surrounding control logic.

---
 rtl/seq_det_ctrl_if.sv | 35 +++
 rtl/seq_det_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl_if.sv
// Control/config/serial bundle between seq_det_ctrl and its surrounding logic.
interface seq_det_ctrl_if #(
  parameter int W     = 16,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [W-1:0]     cfg_pattern;
  logic [W-1:0]     cfg_mask;
  logic [CNT_W-1:0] cfg_target;
  logic [TO_W-1:0]  cfg_timeout;
  logic             cfg_overlap;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             In;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_timeout, cfg_overlap,
    output start, abort, in_valid, In,
    input  cfg_ready, busy, done, timed_out, match_pulse, match_cnt
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_timeout, cfg_overlap,
    input  start, abort, in_valid, In,
    output cfg_ready, busy, done, timed_out, match_pulse, match_cnt
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-controlled serial sequence detector: masked pattern compare on a
// W-bit LSB-first shift register, with fill guard, overlap policy, match
// target and cycle timeout.
module seq_det_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_ctrl_if.slave  bus
);

  localparam int FW = $clog2(W + 1);
  localparam logic [FW-1:0] FULL = FW'(W);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0]     pattern;
    logic [W-1:0]     mask;
    logic [CNT_W-1:0] target;
    logic [TO_W-1:0]  timeout;
    logic             overlap;
  } cfg_t;

  state_t           state, state_nxt;
  cfg_t             cfg;
  logic [W-1:0]     sr, sr_nxt;
  logic [FW-1:0]    fill, fill_inc;
  logic [TO_W-1:0]  to_cnt, to_inc;
  logic [CNT_W-1:0] match_cnt, mcnt_inc, tgt;
  logic             match_pulse, timed_out;
  logic             armed, run_start, acc, hit, fin_match, expire, cfg_acc;

  // Per-cycle decode: accepted bit, post-shift compare, finish and timeout.
  // abort suppresses every run-side effect in the cycle it is seen.
  always_comb begin
    armed     = (state == S_ARMED);
    run_start = !armed && bus.start && !bus.abort;
    acc       = armed && !bus.abort && bus.in_valid;
    sr_nxt    = {bus.In, sr[W-1:1]};
    fill_inc  = (fill == FULL) ? FULL : fill + 1'b1;
    hit       = acc && (fill_inc == FULL) &&
                (((sr_nxt ^ cfg.pattern) & cfg.mask) == '0);
    mcnt_inc  = match_cnt + 1'b1;
    tgt       = (cfg.target == '0) ? CNT_W'(1) : cfg.target;
    fin_match = hit && (mcnt_inc == tgt);
    to_inc    = to_cnt + 1'b1;
    expire    = armed && !bus.abort && (cfg.timeout != '0) &&
                (to_inc == cfg.timeout);
    cfg_acc   = bus.cfg_valid && !armed;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: abort wins over everything, a completing match wins
  // over a same-cycle timeout (both lead to DONE, timed_out decides).
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) state_nxt = S_ARMED;
        S_ARMED:        if (fin_match || expire) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: status levels come straight from the state.
  always_comb begin
    bus.cfg_ready   = !armed;
    bus.busy        = armed;
    bus.done        = (state == S_DONE);
    bus.timed_out   = timed_out;
    bus.match_pulse = match_pulse;
    bus.match_cnt   = match_cnt;
  end

  // Config latch; only accepted outside a run so an armed run never changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg <= '0;
    end else if (cfg_acc) begin
      cfg.pattern <= bus.cfg_pattern;
      cfg.mask    <= bus.cfg_mask;
      cfg.target  <= bus.cfg_target;
      cfg.timeout <= bus.cfg_timeout;
      cfg.overlap <= bus.cfg_overlap;
    end
  end

  // Detection shift register; newest bit enters at the top, frozen outside runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sr <= '0;
    else if (acc) sr <= sr_nxt;
  end

  // Run counters and status: cleared on start, advanced while armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill        <= '0;
      to_cnt      <= '0;
      match_cnt   <= '0;
      match_pulse <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (run_start) begin
        fill      <= '0;
        to_cnt    <= '0;
        match_cnt <= '0;
        timed_out <= 1'b0;
      end else if (bus.abort) begin
        timed_out <= 1'b0;
      end else if (armed) begin
        to_cnt <= to_inc;
        if (acc)  fill      <= (hit && !cfg.overlap) ? '0 : fill_inc;
        if (hit)  match_cnt <= mcnt_inc;
        if (expire && !fin_match) timed_out <= 1'b1;
      end
    end
  end

endmodule
